// File: rtl/sub_bytes_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sub_bytes_iter_pkg
// Desc    : Shared cipher types, forward/inverse S-box tables and FSM encoding
// Revision: 1.0
// ============================================================================
package sub_bytes_iter_pkg;

    localparam int CIPHER_NB = 4;

    // Packed so that byte k = row*NB + col sits at flat index k, [0][0] in the MSBs
    typedef logic [0:3][0:CIPHER_NB-1][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

endpackage
`default_nettype wire

// File: rtl/sub_bytes_iter_if.sv
`default_nettype none
// ============================================================================
// Module  : sub_bytes_iter_if
// Desc    : Input/output valid-ready channels of the SubBytes engine
// Revision: 1.0
// ============================================================================
interface sub_bytes_iter_if #(
    parameter int NB = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [0:3][0:NB-1][7:0] in_state;
    logic                    in_inv;
    logic                    out_valid;
    logic                    out_ready;
    logic [0:3][0:NB-1][7:0] out_state;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface
`default_nettype wire

// File: rtl/sub_bytes_iter_sbox_lane.sv
`default_nettype none
// ============================================================================
// Module  : sbox_lane
// Desc    : One combinational forward/inverse S-box byte lane
// Revision: 1.0
// ============================================================================
module sbox_lane
    import sub_bytes_iter_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);
    assign dout = inv ? INV_SBOX[din] : SBOX[din];
endmodule
`default_nettype wire

// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module  : sub_bytes_iter
// Desc    : Iterative SubBytes/InvSubBytes engine, LANES bytes per clock
// Revision: 1.0
// ============================================================================
module sub_bytes_iter
    import sub_bytes_iter_pkg::*;
#(
    parameter int LANES = 4,
    parameter int NB    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sub_bytes_iter_if.slave  bus
);
    localparam int NBYTES = 4 * NB;
    localparam int STEPS  = NBYTES / LANES;
    localparam int IDX_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int BYTE_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    fsm_state_t                 r_state;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_inv;
    logic                       r_out_valid;
    // Flat row-major views of the state: index k maps to [k / NB][k % NB]
    logic [0:NBYTES-1][7:0]     r_src;
    logic [0:NBYTES-1][7:0]     r_res;

    logic [BYTE_W-1:0]          w_sel      [LANES];
    logic [7:0]                 w_lane_in  [LANES];
    logic [7:0]                 w_lane_out [LANES];
    logic                       w_in_ready;
    logic                       w_accept;

    assign w_in_ready    = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_accept      = bus.in_valid && w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_res;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_sel[j]     = BYTE_W'(int'(r_idx) * LANES + j);
        assign w_lane_in[j] = r_src[w_sel[j]];

        sbox_lane u_lane (
            .din  (w_lane_in[j]),
            .inv  (r_inv),
            .dout (w_lane_out[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
            r_src       <= '0;
            r_res       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src   <= bus.in_state;
                        r_inv   <= bus.in_inv;
                        r_idx   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        r_res[w_sel[j]] <= w_lane_out[j];
                    end
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        // A waiting producer is taken on the completing edge
                        if (bus.in_valid) begin
                            r_src   <= bus.in_state;
                            r_inv   <= bus.in_inv;
                            r_idx   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sub_bytes_iter
// Desc    : Directed known-answer bench over LANES = 4, 1, 16 and 2
// Revision: 1.0
// ============================================================================
module tb_sub_bytes_iter;
    import sub_bytes_iter_pkg::*;

    localparam int N_DUT = 4;
    // Hand-derived cycle counts 16/LANES for each instance
    localparam int STEPS [N_DUT] = '{4, 16, 1, 8};
    localparam state_t SEQ_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam state_t SEQ_FWD = 128'h637c777bf26b6fc53001672bfed7ab76;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid  [N_DUT];
    logic   in_ready  [N_DUT];
    logic   in_inv    [N_DUT];
    state_t in_state  [N_DUT];
    logic   out_valid [N_DUT];
    logic   out_ready [N_DUT];
    state_t out_state [N_DUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 16 : 2;
        sub_bytes_iter_if #(.NB(4)) bus ();

        assign bus.in_valid   = in_valid[gi];
        assign bus.in_state   = in_state[gi];
        assign bus.in_inv     = in_inv[gi];
        assign bus.out_ready  = out_ready[gi];
        assign in_ready[gi]   = bus.in_ready;
        assign out_valid[gi]  = bus.out_valid;
        assign out_state[gi]  = bus.out_state;

        sub_bytes_iter #(.LANES(L), .NB(4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic state_t fill(input logic [7:0] b);
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = b;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a state, holds until accepted, then scrambles the inputs
    task automatic send(input int d, input state_t s, input logic inv);
        int guard;
        guard       = 0;
        in_state[d] = s;
        in_inv[d]   = inv;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        in_valid[d] = 1'b0;
        in_state[d] = ~s;
        in_inv[d]   = ~inv;
    endtask

    task automatic wait_done(input int d, output int cycles);
        cycles = 0;
        while (!out_valid[d] && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic complete(input int d, input string tag);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check_eq({tag, "_valid_drop"}, 128'(out_valid[d]), 128'(0));
        check_eq({tag, "_ready_idle"}, 128'(in_ready[d]), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     cyc;
        state_t s;
        state_t e;
        state_t fwd;

        for (int d = 0; d < N_DUT; d++) begin
            in_valid[d]  = 1'b0;
            in_inv[d]    = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < N_DUT; d++) begin
            check_eq($sformatf("rst_valid_%0d", d), 128'(out_valid[d]), 128'(0));
            check_eq($sformatf("rst_state_%0d", d), out_state[d], '0);
            check_eq($sformatf("rst_ready_%0d", d), 128'(in_ready[d]), 128'(1));
        end

        // LANES=4: all-zero state forward
        send(0, fill(8'h00), 1'b0);
        wait_done(0, cyc);
        check_eq("l4_latency", 128'(cyc), 128'(STEPS[0]));
        check_eq("l4_zero_fwd", out_state[0], fill(8'h63));
        complete(0, "l4");

        // LANES=1: known-answer corners
        s = fill(8'h00);
        s[0][0] = 8'h53;
        s[3][3] = 8'hff;
        e = fill(8'h63);
        e[0][0] = 8'hed;
        e[3][3] = 8'h16;
        send(1, s, 1'b0);
        wait_done(1, cyc);
        check_eq("l1_latency", 128'(cyc), 128'(STEPS[1]));
        check_eq("l1_kat", out_state[1], e);
        complete(1, "l1");

        // LANES=16: inverse in a single cycle
        send(2, fill(8'h63), 1'b1);
        wait_done(2, cyc);
        check_eq("l16_latency", 128'(cyc), 128'(STEPS[2]));
        check_eq("l16_inv", out_state[2], fill(8'h00));
        complete(2, "l16");

        // LANES=2: row-major sequence forward, then back through the inverse
        send(3, SEQ_IN, 1'b0);
        wait_done(3, cyc);
        check_eq("l2_latency_fwd", 128'(cyc), 128'(STEPS[3]));
        check_eq("l2_seq_fwd", out_state[3], SEQ_FWD);
        fwd = out_state[3];
        complete(3, "l2_fwd");
        send(3, fwd, 1'b1);
        wait_done(3, cyc);
        check_eq("l2_latency_inv", 128'(cyc), 128'(STEPS[3]));
        check_eq("l2_round_trip", out_state[3], SEQ_IN);
        complete(3, "l2_inv");

        // LANES=4: backpressure in DONE, then back-to-back accept
        send(0, fill(8'h00), 1'b0);
        wait_done(0, cyc);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("bp_state_%0d", i), out_state[0], fill(8'h63));
            check_eq($sformatf("bp_ready_%0d", i), 128'(in_ready[0]), 128'(0));
            check_eq($sformatf("bp_valid_%0d", i), 128'(out_valid[0]), 128'(1));
        end
        in_state[0]  = SEQ_IN;
        in_inv[0]    = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        check_eq("b2b_ready_comb", 128'(in_ready[0]), 128'(1));
        tick();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        in_state[0]  = '0;
        check_eq("b2b_busy_valid", 128'(out_valid[0]), 128'(0));
        check_eq("b2b_busy_ready", 128'(in_ready[0]), 128'(0));
        wait_done(0, cyc);
        check_eq("b2b_latency", 128'(cyc), 128'(STEPS[0]));
        check_eq("b2b_state", out_state[0], SEQ_FWD);
        complete(0, "b2b");

        // LANES=1: reset at idx=7 discards the partial result
        send(1, fill(8'h53), 1'b0);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 128'(out_valid[1]), 128'(0));
        check_eq("mid_rst_state", out_state[1], '0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready", 128'(in_ready[1]), 128'(1));
        check_eq("post_rst_valid", 128'(out_valid[1]), 128'(0));
        check_eq("post_rst_state", out_state[1], '0);
        repeat (20) tick();
        check_eq("post_rst_quiet", 128'(out_valid[1]), 128'(0));
        send(1, fill(8'h00), 1'b0);
        wait_done(1, cyc);
        check_eq("post_rst_latency", 128'(cyc), 128'(STEPS[1]));
        check_eq("post_rst_result", out_state[1], fill(8'h63));
        complete(1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
